// File: rtl/counter_sequencer.sv
// Run controller for the up-counter datapath: counts 0..limit on prescaled ticks,
// with pause/resume, abort, optional auto-reload and a saturating wrap counter.
module counter_sequencer #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned PRESCALE = 1
) (
    input  logic             clk,
    input  logic             clearBar,
    input  logic             start,
    input  logic             pause,
    input  logic             abort,
    input  logic             tick,
    input  logic [WIDTH-1:0] limit,
    input  logic             autoReload,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             paused,
    output logic             done,
    output logic [7:0]       wrapCnt
);
    localparam int unsigned PRE_W  = 8;
    localparam int unsigned WRAP_W = 8;
    localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(PRESCALE - 1);
    localparam logic [WRAP_W-1:0] WRAP_MAX = '1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    logic [1:0]        state, state_nxt;
    logic [WIDTH-1:0]  q_nxt, lim_r, lim_nxt;
    logic [PRE_W-1:0]  pre, pre_nxt;
    logic [WRAP_W-1:0] wrap_nxt;
    logic              ar_r, ar_nxt;
    logic              done_nxt, busy_nxt, paused_nxt;

    // State and datapath registers; reset discards any run in progress.
    always_ff @(posedge clk or negedge clearBar) begin
        if (!clearBar) begin
            state   <= IDLE;
            q       <= '0;
            pre     <= '0;
            lim_r   <= '0;
            ar_r    <= 1'b0;
            done    <= 1'b0;
            busy    <= 1'b0;
            paused  <= 1'b0;
            wrapCnt <= '0;
        end else begin
            state   <= state_nxt;
            q       <= q_nxt;
            pre     <= pre_nxt;
            lim_r   <= lim_nxt;
            ar_r    <= ar_nxt;
            done    <= done_nxt;
            busy    <= busy_nxt;
            paused  <= paused_nxt;
            wrapCnt <= wrap_nxt;
        end
    end

    // Next-state and next-output logic; priority in RUN is abort > pause > advance.
    always_comb begin
        state_nxt = state;
        q_nxt     = q;
        pre_nxt   = pre;
        lim_nxt   = lim_r;
        ar_nxt    = ar_r;
        wrap_nxt  = wrapCnt;
        done_nxt  = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    lim_nxt   = limit;
                    ar_nxt    = autoReload;
                    q_nxt     = '0;
                    pre_nxt   = '0;
                    wrap_nxt  = '0;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    q_nxt     = '0;
                    pre_nxt   = '0;
                    state_nxt = IDLE;
                end else if (pause) begin
                    state_nxt = HOLD;
                end else if (tick) begin
                    if (pre == PRE_LAST) begin
                        pre_nxt = '0;
                        if (q == lim_r) begin
                            done_nxt = 1'b1;
                            if (ar_r) begin
                                q_nxt = '0;
                                if (wrapCnt != WRAP_MAX) begin
                                    wrap_nxt = wrapCnt + WRAP_W'(1);
                                end
                            end else begin
                                state_nxt = IDLE;
                            end
                        end else begin
                            q_nxt = q + WIDTH'(1);
                        end
                    end else begin
                        pre_nxt = pre + PRE_W'(1);
                    end
                end
            end
            HOLD: begin
                if (abort) begin
                    q_nxt     = '0;
                    pre_nxt   = '0;
                    state_nxt = IDLE;
                end else if (!pause) begin
                    state_nxt = RUN;
                end
            end
            default: begin
                q_nxt     = '0;
                pre_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase

        busy_nxt   = (state_nxt == RUN) || (state_nxt == HOLD);
        paused_nxt = (state_nxt == HOLD);
    end
endmodule
